// File: rtl/datapath_ctrl_if.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_if
// Purpose : groups the instruction handshake and the datapath control bus of
//           datapath_ctrl into one bundle.
// Signals :
//   start, instr          instruction source -> controller
//   ready, done           controller -> instruction source
//   r_addr, w_addr, w_en  regfile control
//   loada/b/c, loads      pipeline register / status load strobes
//   asel, vsel            ALU A-input and writeback mux selects
//   alu_op, shift, sximm8 decoded instruction fields
//   halted                only with CTRL_ILLEGAL_TRAP_EN defined
// Modports: master = instruction source / datapath side, slave = controller.
// -----------------------------------------------------------------------------
interface datapath_ctrl_if;
  logic        start;
  logic [15:0] instr;
  logic        ready;
  logic        done;
  logic [2:0]  r_addr;
  logic [2:0]  w_addr;
  logic        w_en;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        vsel;
  logic [1:0]  alu_op;
  logic [1:0]  shift;
  logic [15:0] sximm8;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        halted;

  modport master (
    output start, instr,
    input  ready, done, r_addr, w_addr, w_en, loada, loadb, loadc, loads,
           asel, vsel, alu_op, shift, sximm8, halted
  );
  modport slave (
    input  start, instr,
    output ready, done, r_addr, w_addr, w_en, loada, loadb, loadc, loads,
           asel, vsel, alu_op, shift, sximm8, halted
  );
`else
  modport master (
    output start, instr,
    input  ready, done, r_addr, w_addr, w_en, loada, loadb, loadc, loads,
           asel, vsel, alu_op, shift, sximm8
  );
  modport slave (
    input  start, instr,
    output ready, done, r_addr, w_addr, w_en, loada, loadb, loadc, loads,
           asel, vsel, alu_op, shift, sximm8
  );
`endif
endinterface

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
// Purpose : Moore FSM sequencing the regfile / A-B-C registers / shifter-ALU
//           datapath one 16-bit instruction at a time. An instruction is
//           latched on start && ready, then the FSM drives read/write
//           addresses, load strobes and mux selects until it retires with a
//           one-cycle done pulse.
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset; also forces every strobe,
//                done and ready low combinationally while asserted
//           bus  datapath_ctrl_if.slave (handshake + datapath control)
// Params  : SXT_IMM 1: sximm8 sign-extends ir[7:0], 0: zero-extends
// Macro   : CTRL_ILLEGAL_TRAP_EN - unlisted encodings go to HALT (left only
//           by rst) and drive bus.halted; otherwise they retire as a NOP.
//
// State    | meaning
// S_WAIT   | idle, ready=1, accepts an instruction
// S_GET_A  | read Rn, load A
// S_GET_B  | read Rm, load B
// S_EXEC   | ALU cycle: load C, or status flags + done for CMP
// S_WR_RD  | write C to Rd, done
// S_WR_IMM | write sximm8 to Rn, done
// S_NOP    | unlisted encoding retires, done only (trap disabled)
// S_HALT   | unlisted encoding trapped, halted=1 (trap enabled)
// -----------------------------------------------------------------------------
module datapath_ctrl #(
  parameter bit SXT_IMM = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  datapath_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_RD,
    S_WR_IMM,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_HALT
`else
    S_NOP
`endif
  } state_t;

  state_t      r_state;
  state_t      w_nxt_state;
  logic [15:0] r_ir;
  logic [15:0] w_nxt_ir;

  logic        r_ready;
  logic        r_done;
  logic        r_w_en;
  logic        r_loada;
  logic        r_loadb;
  logic        r_loadc;
  logic        r_loads;
  logic        r_asel;
  logic        r_vsel;
  logic [2:0]  r_raddr;
  logic [2:0]  r_waddr;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        r_halted;
`endif

  function automatic logic f_is_cmp(input logic [15:0] ins);
    return ins[15:11] == 5'b101_01;
  endfunction

  function automatic logic f_is_movr(input logic [15:0] ins);
    return ins[15:11] == 5'b110_00;
  endfunction

  // First state after accept, keyed on {opcode, op}.
  function automatic state_t f_entry(input logic [15:0] ins);
    state_t s;
    case (ins[15:11])
      5'b110_10:                     s = S_WR_IMM;
      5'b110_00, 5'b101_11:          s = S_GET_B;
      5'b101_00, 5'b101_10,
      5'b101_01:                     s = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
      default:                       s = S_HALT;
`else
      default:                       s = S_NOP;
`endif
    endcase
    return s;
  endfunction

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ir    = r_ir;
    case (r_state)
      S_WAIT: begin
        if (bus.start) begin
          w_nxt_ir    = bus.instr;
          w_nxt_state = f_entry(bus.instr);
        end
      end
      S_GET_A:  w_nxt_state = S_GET_B;
      S_GET_B:  w_nxt_state = S_EXEC;
      S_EXEC:   w_nxt_state = f_is_cmp(r_ir) ? S_WAIT : S_WR_RD;
      S_WR_RD:  w_nxt_state = S_WAIT;
      S_WR_IMM: w_nxt_state = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:   w_nxt_state = S_HALT;
`else
      S_NOP:    w_nxt_state = S_WAIT;
`endif
      default:  w_nxt_state = S_WAIT;
    endcase
  end

  // Outputs are registered from the next state / next IR so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_w_en  <= 1'b0;
      r_loada <= 1'b0;
      r_loadb <= 1'b0;
      r_loadc <= 1'b0;
      r_loads <= 1'b0;
      r_asel  <= 1'b0;
      r_vsel  <= 1'b0;
      r_raddr <= '0;
      r_waddr <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_halted <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_ir    <= w_nxt_ir;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_w_en  <= 1'b0;
      r_loada <= 1'b0;
      r_loadb <= 1'b0;
      r_loadc <= 1'b0;
      r_loads <= 1'b0;
      r_asel  <= 1'b0;
      r_vsel  <= 1'b0;
      r_raddr <= '0;
      r_waddr <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_halted <= 1'b0;
`endif
      case (w_nxt_state)
        S_WAIT:  r_ready <= 1'b1;
        S_GET_A: begin
          r_raddr <= w_nxt_ir[10:8];
          r_loada <= 1'b1;
        end
        S_GET_B: begin
          r_raddr <= w_nxt_ir[2:0];
          r_loadb <= 1'b1;
        end
        S_EXEC: begin
          // CMP only updates the flags and retires here.
          if (f_is_cmp(w_nxt_ir)) begin
            r_loads <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_loadc <= 1'b1;
          end
          // MOV Rd,Rm passes B through the ALU with A forced to zero.
          r_asel <= f_is_movr(w_nxt_ir);
        end
        S_WR_RD: begin
          r_waddr <= w_nxt_ir[7:5];
          r_w_en  <= 1'b1;
          r_done  <= 1'b1;
        end
        S_WR_IMM: begin
          r_waddr <= w_nxt_ir[10:8];
          r_vsel  <= 1'b1;
          r_w_en  <= 1'b1;
          r_done  <= 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_HALT:  r_halted <= 1'b1;
`else
        S_NOP:   r_done <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Gating with rst suppresses a write that is in flight when reset hits.
  assign bus.ready  = r_ready & ~rst;
  assign bus.done   = r_done  & ~rst;
  assign bus.w_en   = r_w_en  & ~rst;
  assign bus.loada  = r_loada & ~rst;
  assign bus.loadb  = r_loadb & ~rst;
  assign bus.loadc  = r_loadc & ~rst;
  assign bus.loads  = r_loads & ~rst;
  assign bus.asel   = r_asel;
  assign bus.vsel   = r_vsel;
  assign bus.r_addr = r_raddr;
  assign bus.w_addr = r_waddr;
  assign bus.alu_op = r_ir[12:11];
  assign bus.shift  = r_ir[4:3];
  assign bus.sximm8 = SXT_IMM ? {{8{r_ir[7]}}, r_ir[7:0]} : {8'h00, r_ir[7:0]};
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.halted = r_halted;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl
// Purpose : self-checking bench for datapath_ctrl. Each instruction is
//           expanded by a small model into the list of per-cycle control
//           words it should produce, and the DUT is compared cycle by cycle.
//           A second instance with SXT_IMM=0 shares the stimulus.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  datapath_ctrl_if u_if ();
  datapath_ctrl_if u_if0 ();

  assign u_if0.start = u_if.start;
  assign u_if0.instr = u_if.instr;

  datapath_ctrl #(.SXT_IMM(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  datapath_ctrl #(.SXT_IMM(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u_if0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        done;
    logic        w_en;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        vsel;
    logic [2:0]  r_addr;
    logic [2:0]  w_addr;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic [15:0] sximm8;
  } obs_t;

  obs_t        exp_q[$];
  logic [15:0] cur_ir;

  function automatic obs_t sample();
    obs_t s;
    s.ready  = u_if.ready;
    s.done   = u_if.done;
    s.w_en   = u_if.w_en;
    s.loada  = u_if.loada;
    s.loadb  = u_if.loadb;
    s.loadc  = u_if.loadc;
    s.loads  = u_if.loads;
    s.asel   = u_if.asel;
    s.vsel   = u_if.vsel;
    s.r_addr = u_if.r_addr;
    s.w_addr = u_if.w_addr;
    s.alu_op = u_if.alu_op;
    s.shift  = u_if.shift;
    s.sximm8 = u_if.sximm8;
    return s;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [15:0] sext8(input logic [15:0] ins);
    int v;
    v = int'(ins[7:0]);
    if (v > 127) v = v - 256;
    return 16'(v);
  endfunction

  function automatic obs_t base_rec(input logic [15:0] ins, input logic rdy);
    obs_t o;
    o        = '0;
    o.ready  = rdy;
    o.alu_op = ins[12:11];
    o.shift  = ins[4:3];
    o.sximm8 = sext8(ins);
    return o;
  endfunction

  // Expand one instruction into the control words of its busy cycles.
  function automatic void build(input logic [15:0] ins);
    obs_t    o;
    int      opc, op;
    bit      is_alu, use_a, is_cmp, is_movr;
    opc     = int'(ins[15:13]);
    op      = int'(ins[12:11]);
    is_alu  = (opc == 5) || (opc == 6 && op == 0);
    use_a   = (opc == 5) && (op != 3);
    is_cmp  = (opc == 5) && (op == 1);
    is_movr = (opc == 6) && (op == 0);
    if (opc == 6 && op == 2) begin
      o = base_rec(ins, 1'b0);
      o.w_addr = ins[10:8]; o.vsel = 1'b1; o.w_en = 1'b1; o.done = 1'b1;
      exp_q.push_back(o);
    end else if (is_alu) begin
      if (use_a) begin
        o = base_rec(ins, 1'b0);
        o.r_addr = ins[10:8]; o.loada = 1'b1;
        exp_q.push_back(o);
      end
      o = base_rec(ins, 1'b0);
      o.r_addr = ins[2:0]; o.loadb = 1'b1;
      exp_q.push_back(o);
      o = base_rec(ins, 1'b0);
      o.asel = is_movr;
      if (is_cmp) begin o.loads = 1'b1; o.done = 1'b1; end
      else        o.loadc = 1'b1;
      exp_q.push_back(o);
      if (!is_cmp) begin
        o = base_rec(ins, 1'b0);
        o.w_addr = ins[7:5]; o.w_en = 1'b1; o.done = 1'b1;
        exp_q.push_back(o);
      end
    end else begin
      o = base_rec(ins, 1'b0);
      o.done = 1'b1;
      exp_q.push_back(o);
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic cmp_idle(input string tag);
    obs_t g, e;
    g = sample();
    e = base_rec(cur_ir, 1'b1);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s idle: got %h expected %h", tag, g, e);
    end
  endtask

  // Compare queued busy cycles; with noise, start/instr toggle randomly
  // while the FSM is busy and must be ignored.
  task automatic drain(input string tag, input logic [15:0] ins, input bit noise);
    obs_t g, e;
    int   k;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s cyc%0d instr=%h: got %h expected %h", tag, k, ins, g, e);
      end
      if (noise) begin
        u_if.start = 1'($urandom_range(0, 1));
        u_if.instr = 16'($urandom);
      end
      if (exp_q.size() > 0) @(negedge clk);
      k++;
    end
  endtask

  task automatic run_seq(input string tag, input logic [15:0] ins, input bit noise);
    cmp_idle({tag, "_pre"});
    build(ins);
    u_if.start = 1'b1;
    u_if.instr = ins;
    @(negedge clk);
    u_if.start = 1'b0;
    if (noise) u_if.instr = 16'($urandom);
    drain(tag, ins, noise);
    @(negedge clk);
    u_if.start = 1'b0;
    cur_ir = ins;
    cmp_idle({tag, "_post"});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t g;
    rst = 1'b1;
    u_if.start = 1'b0;
    u_if.instr = 16'h0;
    @(negedge clk);
    g = sample();
    checks++;
    if ({g.ready, g.done, g.w_en, g.loada, g.loadb, g.loadc, g.loads} !== 7'b0) begin
      errors++;
      $display("FAIL reset_gate: got %b expected 0000000",
               {g.ready, g.done, g.w_en, g.loada, g.loadb, g.loadc, g.loads});
    end
    rst = 1'b0;
    cur_ir = 16'h0;
    @(negedge clk);
    cmp_idle("reset_release");
  endtask

  task automatic test_mov_imm();
    run_seq("mov_imm", 16'hD3FB, 1'b0);
    checks++;
    if (u_if.sximm8 !== 16'hFFFB) begin
      errors++;
      $display("FAIL sximm8_sext: got %h expected FFFB", u_if.sximm8);
    end
    checks++;
    if (u_if0.sximm8 !== 16'h00FB) begin
      errors++;
      $display("FAIL sximm8_zext: got %h expected 00FB", u_if0.sximm8);
    end
  endtask

  task automatic test_alu_ops();
    run_seq("add", 16'hA140, 1'b0);
    run_seq("cmp", 16'hAD06, 1'b0);
    run_seq("and", 16'hB3B9, 1'b1);
    run_seq("mvn", 16'hB8F5, 1'b1);
    run_seq("mov_reg", 16'hC0E3, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] i1, i2;
    i1 = {5'b110_00, 11'($urandom)};
    i2 = {5'b101_11, 11'($urandom)};
    cmp_idle("b2b_pre");
    build(i1);
    u_if.start = 1'b1;
    u_if.instr = i1;
    @(negedge clk);
    u_if.instr = i2;
    drain("b2b_first", i1, 1'b0);
    @(negedge clk);
    cur_ir = i1;
    cmp_idle("b2b_gap");
    build(i2);
    @(negedge clk);
    u_if.start = 1'b0;
    drain("b2b_second", i2, 1'b0);
    @(negedge clk);
    cur_ir = i2;
    cmp_idle("b2b_post");
  endtask

  task automatic test_reset_write();
    obs_t g, e;
    cmp_idle("rstwr_pre");
    build(16'hA140);
    u_if.start = 1'b1;
    u_if.instr = 16'hA140;
    @(negedge clk);
    u_if.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rstwr cyc%0d: got %h expected %h", k, g, e);
      end
      if (k < 2) @(negedge clk);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    g = sample();
    checks++;
    if ({g.ready, g.done, g.w_en, g.loada, g.loadb, g.loadc, g.loads} !== 7'b0) begin
      errors++;
      $display("FAIL rstwr_suppress: got %b expected 0000000",
               {g.ready, g.done, g.w_en, g.loada, g.loadb, g.loadc, g.loads});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cur_ir = 16'h0;
    @(negedge clk);
    cmp_idle("rstwr_after");
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    u_if.start = 1'b1;
    u_if.instr = 16'hE000;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (u_if.halted !== 1'b1 || u_if.ready !== 1'b0 || u_if.w_en !== 1'b0 || u_if.done !== 1'b0) begin
        errors++;
        $display("FAIL halt cyc%0d: got halted=%b ready=%b w_en=%b done=%b expected 1 0 0 0",
                 k, u_if.halted, u_if.ready, u_if.w_en, u_if.done);
      end
      @(negedge clk);
    end
    u_if.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_ir = 16'h0;
    @(negedge clk);
    checks++;
    if (u_if.halted !== 1'b0 || u_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL halt_exit: got halted=%b ready=%b expected 0 1", u_if.halted, u_if.ready);
    end
`else
    run_seq("illegal_e000", 16'hE000, 1'b0);
    run_seq("illegal_c8", 16'hC8A5, 1'b1);
`endif
  endtask

  task automatic test_random();
    logic [4:0]  legal [6];
    logic [4:0]  code;
    logic [15:0] ins;
    legal = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_10, 5'b101_01, 5'b101_11};
    for (int i = 0; i < 30; i++) begin
      code = legal[$urandom_range(0, 5)];
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 5) == 0) begin
        code = 5'($urandom);
        if (code[4:3] == 2'b10 || code == 5'b110_10 || code == 5'b110_00) code = 5'b111_01;
      end
`endif
      ins = {code, 11'($urandom)};
      run_seq("random", ins, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_ir = 16'h0;
    test_reset();
    test_mov_imm();
    test_alu_ops();
    test_back_to_back();
    test_reset_write();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
